// File: rtl/taylor_trig_booth_unit.sv
// rtl/taylor_trig_booth_unit.sv - Taylor-series sin/cos evaluator on one shared radix-2 Booth multiplier
// Each series term is t = ((t*r_k)*x)*x, accumulated with alternating sign.
module taylor_trig_booth_unit #(
    parameter int W      = 16,
    parameter int NTERMS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_sel_cos,
    input  logic signed [W-1:0] i_x_in,
    output logic                o_busy,
    output logic                o_done,
    output logic signed [W-1:0] o_y_out
);
    typedef enum logic [2:0] {S_IDLE, S_MLOAD, S_MSTEP, S_MDONE, S_ACC, S_FIN} state_t;

    localparam int         CW    = $clog2(W + 1);
    localparam logic [2:0] KLAST = 3'(NTERMS - 1);
    localparam logic [W-1:0] ONE = {2'b01, {(W-2){1'b0}}};

    function automatic int ratio(input int k, input bit is_cos);
        int d;
        if (k == 0) return 0;
        d = is_cos ? (2*k - 1) * (2*k) : (2*k) * (2*k + 1);
        return ((1 << (W - 2)) + d / 2) / d;
    endfunction

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_mul;
    logic [2:0]            r_k;
    logic                  r_cos, r_q1, r_done;
    logic signed [W-1:0]   r_x, r_t, r_acc, r_y;
    logic signed [W:0]     r_a, r_m;
    logic [W-1:0]          r_q;

    logic [W-1:0]          w_sin_tab [0:7];
    logic [W-1:0]          w_cos_tab [0:7];
    logic [W-1:0]          w_ratio, w_mcand;
    logic signed [W:0]     w_sum;
    logic signed [2*W:0]   w_prod, w_shift;
    logic                  w_prod_fits;
    logic [W-1:0]          w_prod_sat;
    logic signed [W:0]     w_accsum;
    logic [W-1:0]          w_acc_sat;

    for (genvar g = 0; g < 8; g++) begin : g_ratio
        localparam int SIN_R = ratio(g, 1'b0);
        localparam int COS_R = ratio(g, 1'b1);
        assign w_sin_tab[g] = SIN_R[W-1:0];
        assign w_cos_tab[g] = COS_R[W-1:0];
    end

    assign w_ratio = r_cos ? w_cos_tab[r_k] : w_sin_tab[r_k];
    assign w_mcand = (r_mul == 2'd0) ? w_ratio : r_x;

    // A is one bit wider than the operands so subtracting M = -2^(W-1) cannot overflow.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_prod      = {r_a, r_q};
    assign w_shift     = w_prod >>> (W - 2);
    assign w_prod_fits = (&w_shift[2*W:W-1]) | ~(|w_shift[2*W:W-1]);
    assign w_prod_sat  = w_prod_fits ? w_shift[W-1:0]
                                     : {w_shift[2*W], {(W-1){~w_shift[2*W]}}};

    assign w_accsum  = r_k[0] ? ({r_acc[W-1], r_acc} - {r_t[W-1], r_t})
                              : ({r_acc[W-1], r_acc} + {r_t[W-1], r_t});
    assign w_acc_sat = (w_accsum[W] == w_accsum[W-1]) ? w_accsum[W-1:0]
                                                      : {w_accsum[W], {(W-1){~w_accsum[W]}}};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (NTERMS == 1) ? S_FIN : S_MLOAD;
            S_MLOAD: w_next = S_MSTEP;
            S_MSTEP: if (r_cnt == CW'(1)) w_next = S_MDONE;
            S_MDONE: w_next = (r_mul == 2'd2) ? S_ACC : S_MLOAD;
            S_ACC:   w_next = (r_k == KLAST) ? S_FIN : S_MLOAD;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mul  <= '0;
            r_k    <= '0;
            r_cos  <= 1'b0;
            r_q1   <= 1'b0;
            r_done <= 1'b0;
            r_x    <= '0;
            r_t    <= '0;
            r_acc  <= '0;
            r_y    <= '0;
            r_a    <= '0;
            r_m    <= '0;
            r_q    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_x   <= i_x_in;
                    r_cos <= i_sel_cos;
                    r_t   <= i_sel_cos ? ONE : i_x_in;
                    r_acc <= i_sel_cos ? ONE : i_x_in;
                    r_k   <= 3'd1;
                    r_mul <= 2'd0;
                end
                S_MLOAD: begin
                    r_m   <= {w_mcand[W-1], w_mcand};
                    r_q   <= r_t;
                    r_q1  <= 1'b0;
                    r_a   <= '0;
                    r_cnt <= CW'(W);
                end
                S_MSTEP: begin
                    r_a   <= {w_sum[W], w_sum[W:1]};
                    r_q   <= {w_sum[0], r_q[W-1:1]};
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                end
                S_MDONE: begin
                    r_t   <= w_prod_sat;
                    r_mul <= (r_mul == 2'd2) ? 2'd0 : r_mul + 2'd1;
                end
                S_ACC: begin
                    r_acc <= w_acc_sat;
                    r_k   <= r_k + 3'd1;
                end
                S_FIN: begin
                    r_y    <= r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy  = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done  = r_done;
    assign o_y_out = r_y;
endmodule

// File: tb/tb_taylor_trig_booth_unit.sv
// tb/tb_taylor_trig_booth_unit.sv - bench for taylor_trig_booth_unit against a real-valued sin/cos model
module tb_taylor_trig_booth_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic               start = 1'b0, sel_cos = 1'b0;
    logic signed [15:0] x_in = '0;
    logic               busy, done;
    logic signed [15:0] y;

    logic               n_start = 1'b0, n_sel = 1'b0;
    logic signed [15:0] n_x = '0;
    logic               n_busy, n_done;
    logic signed [15:0] n_y;

    logic               s20_start = 1'b0, s20_sel = 1'b0;
    logic signed [19:0] s20_x = '0;
    logic               s20_busy, s20_done;
    logic signed [19:0] s20_y;

    taylor_trig_booth_unit #(.W(16), .NTERMS(5)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_sel_cos(sel_cos), .i_x_in(x_in),
        .o_busy(busy), .o_done(done), .o_y_out(y));

    taylor_trig_booth_unit #(.W(16), .NTERMS(1)) u_n1 (
        .clk(clk), .rst(rst), .i_start(n_start), .i_sel_cos(n_sel), .i_x_in(n_x),
        .o_busy(n_busy), .o_done(n_done), .o_y_out(n_y));

    taylor_trig_booth_unit #(.W(20), .NTERMS(8)) u_w20 (
        .clk(clk), .rst(rst), .i_start(s20_start), .i_sel_cos(s20_sel), .i_x_in(s20_x),
        .o_busy(s20_busy), .o_done(s20_done), .o_y_out(s20_y));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int d_cos [4] = '{0, 1, 0, 1};
    int d_x   [4] = '{8192, 8192, -25736, 25736};
    int d_exp [4] = '{7855, 14378, -16384, 0};
    int d_tol [4] = '{4, 4, 8, 8};

    task automatic check(input string tag, input int got, input int exp, input int tol);
        int diff;
        checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ref_trig(input int code, input bit is_cos, input int w);
        real s, xr, f;
        s  = real'(1 << (w - 2));
        xr = code / s;
        f  = is_cos ? $cos(xr) : $sin(xr);
        return $rtoi(f * s + ((f >= 0.0) ? 0.5 : -0.5));
    endfunction

    task automatic run16(input bit is_cos, input int xv, output int lat, output int bcnt);
        int e, n;
        sel_cos = is_cos;
        x_in    = 16'(xv);
        start   = 1'b1;
        e       = cyc + 1;
        @(negedge clk);
        start   = 1'b0;
        x_in    = 16'($urandom);
        sel_cos = 1'($urandom);
        n       = -1;
        bcnt    = 0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                n = cyc;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        lat = (n < 0) ? -1 : n - e;
    endtask

    initial begin
        int lat, bc, xi, e, n, dn, d1, d2, ychg, ylat;
        bit c;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0, 0);
        check("rst_done", done, 0, 0);
        check("rst_y", y, 0, 0);
        check("rst_n1_y", n_y, 0, 0);
        check("rst_w20_y", s20_y, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        run16(1'b0, 0, lat, bc);
        check("sin0_lat", lat, 221, 0);
        check("sin0_busy_cycles", bc, 220, 0);
        check("sin0_y", y, 0, 0);
        @(negedge clk);
        check("done_width", done, 0, 0);
        run16(1'b1, 0, lat, bc);
        check("cos0_lat", lat, 221, 0);
        check("cos0_y", y, 16384, 0);

        for (int i = 0; i < 4; i++) begin
            run16(d_cos[i][0], d_x[i], lat, bc);
            check("directed_lat", lat, 221, 0);
            check("directed_y", y, d_exp[i], d_tol[i]);
        end

        run16(1'b0, -32768, lat, bc);
        check("sin_m2_lat", lat, 221, 0);
        run16(1'b1, -32768, lat, bc);
        check("cos_m2_lat", lat, 221, 0);
        run16(1'b0, 32767, lat, bc);
        check("sin_max_lat", lat, 221, 0);

        for (int i = 0; i < 12; i++) begin
            xi = int'($urandom_range(51470)) - 25735;
            c  = 1'($urandom_range(1));
            run16(c, xi, lat, bc);
            check("rand16_lat", lat, 221, 0);
            check("rand16_y", y, ref_trig(xi, c, 16), 8);
        end

        // Handshake: pulses at accept edge e0, e0+50 (busy), e0+221 (FIN), e0+222 (after done).
        sel_cos = 1'b0;
        x_in    = 16'sd8192;
        start   = 1'b1;
        e       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        dn = 0; d1 = -1; d2 = -1; ychg = 0; ylat = 0;
        while (cyc < e + 480) begin
            start   = (cyc == e + 49) || (cyc == e + 220) || (cyc == e + 221);
            sel_cos = (cyc == e + 221);
            @(negedge clk);
            if (done) begin
                dn++;
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
                ylat = y;
            end else if (d1 >= 0 && d2 < 0 && y != 16'(ylat)) begin
                ychg++;
            end
        end
        start = 1'b0;
        check("hs_done_count", dn, 2, 0);
        check("hs_done1_edge", d1 - e, 221, 0);
        check("hs_done2_edge", d2 - e, 443, 0);
        check("hs_y_stable", ychg, 0, 0);
        check("hs_y2", y, 14378, 4);

        // Reset in mid-computation aborts; a restart two edges later completes normally.
        sel_cos = 1'b1;
        x_in    = 16'sd8192;
        start   = 1'b1;
        e       = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e + 99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0, 0);
        check("abort_done", done, 0, 0);
        check("abort_y", y, 0, 0);
        @(negedge clk);
        run16(1'b0, 8192, lat, bc);
        check("restart_lat", lat, 221, 0);
        check("restart_y", y, 7855, 4);

        n_sel   = 1'b0;
        n_x     = 16'sd12345;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        n_x     = 16'sd0;
        check("n1_early_done", n_done, 0, 0);
        @(negedge clk);
        check("n1_done", n_done, 1, 0);
        check("n1_y", n_y, 12345, 0);
        n_sel   = 1'b1;
        n_x     = -16'sd5000;
        n_start = 1'b1;
        @(negedge clk);
        n_start = 1'b0;
        @(negedge clk);
        check("n1_cos_done", n_done, 1, 0);
        check("n1_cos_y", n_y, 16384, 0);

        for (int i = 0; i < 6; i++) begin
            xi        = int'($urandom_range(823548)) - 411774;
            c         = 1'($urandom_range(1));
            s20_sel   = c;
            s20_x     = 20'(xi);
            s20_start = 1'b1;
            e         = cyc + 1;
            @(negedge clk);
            s20_start = 1'b0;
            n = -1;
            for (int j = 0; j < 1000; j++) begin
                if (s20_done) begin
                    n = cyc;
                    break;
                end
                @(negedge clk);
            end
            check("w20_lat", (n < 0) ? -1 : n - e, 470, 0);
            check("w20_y", s20_y, ref_trig(xi, c, 20), 8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
